uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART serializer and successor to the single-shot one-hot TX unit.
- Configurable data width and stop-bit count.
- One-entry holding buffer with a valid/ready handshake, so user logic or a FIFO can queue the next character during transmission.
- Frames are sent back-to-back with no idle gap.
- Bit timing comes from an external baud "tick" (single-clock pulse once per bit period). The block sits between user logic/FIFO and the board TxD pin.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  in  1  system clock (100 MHz on board); all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  baud tick; one-clock pulse per bit period.
- tx_valid  in  1  tx_data holds a character to queue.
- tx_data  in  DATA_BITS  payload character.
- tx_ready  out  1  holding buffer empty; a character is accepted when tx_valid and tx_ready are both high on a clk edge.
- parity_odd  in  1  parity select, 1 = odd, 0 = even; ignored unless UART_TX_PARITY_EN is defined.
- tx_busy  out  1  high while a frame is on the line.
- TxD  out  1  serial output; idle high.

Behaviour:
- Reset (async assert, sync release): state IDLE, hold_valid=0, tx_ready=1, tx_busy=0, TxD=1, counters 0. Reset mid-frame aborts immediately with TxD=1; the partial frame is not resumed.
- Hold register: tx_ready = ~hold_valid, driven directly from a flop.
  - On accept: hold_data<=tx_data, hold_valid<=1.
  - tx_valid while tx_ready=0 is ignored; no data is overwritten.
  - hold_valid clears in the cycle the shifter loads from it. tx_ready rises the next cycle.
  - Same-cycle load and accept cannot occur, because ready is low during the load.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP. All transitions occur only on cycles with tx_en=1. TxD and tx_busy are registered and change in the cycle after the transition edge.
  - IDLE: if tx_en and hold_valid, load shifter, go to START (TxD=0, tx_busy=1). tx_en without hold_valid has no effect.
  - START -> DATA with bit_cnt=0 (TxD=shift[0]).
  - DATA: each tick shifts right and increments bit_cnt. When bit_cnt==DATA_BITS-1, go to PARITY if enabled, otherwise STOP with stop_cnt=0 (TxD=1).
  - PARITY -> STOP.
  - STOP: each tick increments stop_cnt. When stop_cnt==STOP_BITS-1:
    - if hold_valid: load shifter and go directly to START (zero-gap back-to-back, tx_busy stays 1);
    - else go to IDLE (tx_busy=0, TxD=1).
- Each line bit lasts exactly one tick period.
- Latency from accept (while IDLE) to TxD falling: until the next tx_en, plus 1 clk.
- Frame length in tick periods: 1 + DATA_BITS + STOP_BITS (+1 with parity).
- tx_data and parity_odd are sampled at accept and load respectively. Changes mid-frame do not affect the current frame.
- Counter widths: bit_cnt is $clog2(DATA_BITS) bits; stop_cnt is 1 bit.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is inserted after the last data bit.
  - Parity bit = XOR of the payload XOR parity_odd.
  - parity_odd is latched with the payload when the shifter loads.
- Undefined: no PARITY state, parity_odd is unused, and frames carry no parity bit. The port remains present so instantiations do not change.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=1'b1 and LINE_START=1'b0;
  - DATA_BITS and STOP_BITS legal-range limits, checked at elaboration.
- No sub-module inside the block.
- A separate uart_baud_tick module (CLK_HZ, BAUD parameters; 9600 default) generates tx_en at top level and in the bench.

Test Plan:
1. DATA_BITS=8, STOP_BITS=1, tick every 16 clk, send 0x55 -> TxD per tick: 0,1,0,1,0,1,0,1,0,1 then idle 1; tx_busy high for exactly 10 tick periods.
2. Send 0xA5, then immediately queue 0x3C while tx_ready returns high -> 20 contiguous bit periods, no idle between the two stop/start bits, tx_busy never drops; tx_ready low from accept until the 0x3C load.
3. Hold full (tx_ready=0), present tx_valid with 0xFF for 3 cycles -> not accepted; the transmitted second frame is the earlier queued value.
4. UART_TX_PARITY_EN defined, send 0x07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame is 11 periods.
5. DATA_BITS=7, STOP_BITS=2, send 0x41 -> start 0, bits 1,0,0,0,0,0,1, then two stop periods at 1; total 10 periods.
6. Assert rst_n low during bit 3 of a frame with the hold register full -> TxD=1, tx_busy=0, tx_ready=1 asynchronously; after release, no frame is sent until a new accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encodings, line levels and
// legal parameter ranges.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: one-clock pulse every CLK_HZ/BAUD clocks.
module uart_baud_tick #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART serializer with a one-entry holding buffer and zero-gap back-to-back frames.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 parity_odd,
  output logic                 tx_busy,
  output logic                 TxD
);

  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS out of range");
  end

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 ready_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 load;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    load         = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif

    if (tx_valid && !hold_valid_q) begin
      hold_data_d  = tx_data;
      hold_valid_d = 1'b1;
    end

    if (tx_en) begin
      case (state_q)
        IDLE: load = hold_valid_q;
        START: begin
          state_d   = DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            txd_d      = LINE_IDLE;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            txd_d     = shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          txd_d      = LINE_IDLE;
        end
`endif
        STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            // A queued character starts immediately so frames abut with no idle bit.
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              txd_d   = LINE_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            txd_d      = LINE_IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Load requires hold_valid_q, so it never coincides with an accept.
    if (load) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
      state_d      = START;
      txd_d        = LINE_START;
      busy_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d        = (^hold_data_q) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      txd_q        <= LINE_IDLE;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ~hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign TxD      = txd_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: an 8N1 instance and a 7-bit/2-stop instance
// share a 16-clock baud tick; line bits are compared at every tick.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick;
  logic parity_odd = 1'b0;

  logic       valid8 = 1'b0, ready8, busy8, txd8;
  logic [7:0] data8 = '0;
  logic       valid7 = 1'b0, ready7, busy7, txd7;
  logic [6:0] data7 = '0;

  int n_checks = 0;
  int n_errors = 0;
  int busy_ticks8 = 0, busy_ticks7 = 0, falls8 = 0;
  logic busy8_prev = 1'b0;
  logic exp8_q[$];
  logic exp7_q[$];

  always #5 clk = ~clk;

  uart_baud_tick #(.CLK_HZ(160), .BAUD(10)) u_tick (
    .clk(clk), .rst_n(rst_n), .tick(tick)
  );

  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .tx_en(tick), .tx_valid(valid8), .tx_data(data8),
    .tx_ready(ready8), .parity_odd(parity_odd), .tx_busy(busy8), .TxD(txd8)
  );

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .tx_en(tick), .tx_valid(valid7), .tx_data(data7),
    .tx_ready(ready7), .parity_odd(parity_odd), .tx_busy(busy7), .TxD(txd7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line bits for one frame, bit 0 first on the wire.
  function automatic logic [15:0] frame_bits(input int db, input int sb, input logic [8:0] d,
                                             input logic odd, output int len);
    logic [15:0] b;
    logic p;
    int k;
    b = '1;
    k = 0;
    b[k] = 1'b0;
    k++;
    p = odd;
    for (int i = 0; i < db; i++) begin
      b[k] = d[i];
      p ^= d[i];
      k++;
    end
    if (PAR != 0) begin
      b[k] = p;
      k++;
    end
    for (int i = 0; i < sb; i++) begin
      b[k] = 1'b1;
      k++;
    end
    len = k;
    return b;
  endfunction

  // Line monitors: at a tick the line still shows the bit of the period ending now.
  always @(negedge clk) begin
    if (rst_n && tick) begin
      if (busy8) begin
        busy_ticks8++;
        if (exp8_q.size() == 0) check("tx8_unexpected_bit", exp8_q.size(), 1);
        else check("tx8_bit", txd8, exp8_q.pop_front());
      end else begin
        check("tx8_idle_line", txd8, 1);
      end
      if (busy7) begin
        busy_ticks7++;
        if (exp7_q.size() == 0) check("tx7_unexpected_bit", exp7_q.size(), 1);
        else check("tx7_bit", txd7, exp7_q.pop_front());
      end else begin
        check("tx7_idle_line", txd7, 1);
      end
    end
    if (rst_n && busy8_prev && !busy8) falls8++;
    busy8_prev = busy8;
  end

  task automatic send8(input logic [7:0] d);
    int n = 0;
    int len;
    logic [15:0] b;
    @(negedge clk);
    while (!ready8 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) check("send8_timeout", ready8, 1);
    valid8 = 1'b1;
    data8  = d;
    b = frame_bits(8, 1, {1'b0, d}, parity_odd, len);
    for (int i = 0; i < len; i++) exp8_q.push_back(b[i]);
    @(negedge clk);
    valid8 = 1'b0;
    check("send8_ready_low_after_accept", ready8, 0);
  endtask

  task automatic send7(input logic [6:0] d);
    int n = 0;
    int len;
    logic [15:0] b;
    @(negedge clk);
    while (!ready7 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready7) check("send7_timeout", ready7, 1);
    valid7 = 1'b1;
    data7  = d;
    b = frame_bits(7, 2, {2'b0, d}, parity_odd, len);
    for (int i = 0; i < len; i++) exp7_q.push_back(b[i]);
    @(negedge clk);
    valid7 = 1'b0;
    check("send7_ready_low_after_accept", ready7, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    int pending;
    pending = 1;
    while (pending != 0 && n < 3000) begin
      @(negedge clk);
      n++;
      pending = exp8_q.size() + exp7_q.size() + int'(busy8) + int'(busy7) +
                int'(!ready8) + int'(!ready7);
    end
    if (pending != 0) check("idle_timeout", pending, 0);
  endtask

  initial begin
    int t0, f0, n;
    repeat (3) @(negedge clk);
    check("reset_txd", txd8, 1);
    check("reset_busy", busy8, 0);
    check("reset_ready", ready8, 1);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_busy", busy8, 0);

    // 0x55, 8N1
    t0 = busy_ticks8;
    send8(8'h55);
    wait_idle();
    check("t1_busy_ticks", busy_ticks8 - t0, 10 + PAR);

    // Back-to-back frames, plus a rejected write while the holding buffer is full
    t0 = busy_ticks8;
    f0 = falls8;
    send8(8'hA5);
    send8(8'h3C);
    for (int i = 0; i < 3; i++) begin
      valid8 = 1'b1;
      data8  = 8'hFF;
      @(negedge clk);
      check("t3_ready_low_while_full", ready8, 0);
    end
    valid8 = 1'b0;
    wait_idle();
    check("t2_busy_ticks", busy_ticks8 - t0, 2 * (10 + PAR));
    check("t2_busy_single_fall", falls8 - f0, 1);

    // Parity select (no effect when the feature is built out)
    t0 = busy_ticks8;
    parity_odd = 1'b0;
    send8(8'h07);
    wait_idle();
    parity_odd = 1'b1;
    send8(8'h07);
    wait_idle();
    parity_odd = 1'b0;
    check("t4_busy_ticks", busy_ticks8 - t0, 2 * (10 + PAR));

    // 7 data bits, 2 stop bits
    t0 = busy_ticks7;
    send7(7'h41);
    wait_idle();
    check("t5_busy_ticks", busy_ticks7 - t0, 10 + PAR);

    // Reset during bit 3 with the holding buffer full
    send8(8'h96);
    send8(8'h5A);
    n = 0;
    while (!busy8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_frame_started", busy8, 1);
    n = 0;
    for (int k = 0; k < 4 && n < 2000; ) begin
      @(negedge clk);
      n++;
      if (tick) k++;
    end
    check("t6_ready_low_before_reset", ready8, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_txd", txd8, 1);
    check("t6_reset_busy", busy8, 0);
    check("t6_reset_ready", ready8, 1);
    exp8_q.delete();
    exp7_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = busy_ticks8;
    repeat (600) @(negedge clk);
    check("t6_no_resume_ticks", busy_ticks8 - t0, 0);
    check("t6_no_resume_busy", busy8, 0);
    check("t6_no_resume_ready", ready8, 1);
    check("t6_no_resume_txd", txd8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
